// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_stage_pkg                                                   |
// | Purpose  : Shared types and constants for the memory-access stage:         |
// |            datapath widths, RegSrc encodings, load/store funct3 codes and  |
// |            the stage state enum.                                           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mem_stage_pkg;

  localparam int DEF_XLEN   = 64;
  localparam int DEF_ILEN   = 32;
  localparam int REG_ADDR_W = 5;

  // Writeback source select carried with each instruction.
  typedef enum logic [1:0] {
    REGSRC_ALU = 2'd0,
    REGSRC_MEM = 2'd1,
    REGSRC_CSR = 2'd2
  } regsrc_e;

  // Load/store width + signedness, taken from inst[14:12].
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } ls_funct3_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FULL  = 2'd3
  } mem_state_e;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_stage_if                                                    |
// | Purpose  : Bundles the EX-side handshake/payload, the data-bus request/    |
// |            response signals and the WB-side handshake/payload/forwarding   |
// |            outputs of the memory stage.                                    |
// | Modports : master - the memory stage itself                                |
// |            slave  - its environment (EX, data memory, WB)                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mem_stage_if #(
  parameter int XLEN = mem_stage_pkg::DEF_XLEN,
  parameter int ILEN = mem_stage_pkg::DEF_ILEN
);
  // EX side
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [ILEN-1:0] ex_inst;
  logic [XLEN-1:0] ex_ALUres;
  logic [XLEN-1:0] ex_Rs2;
  logic            ex_MemRd;
  logic            ex_MemWr;
  logic [1:0]      ex_RegSrc;
  logic            ex_RegWr;
  logic            ex_isecall;
  logic            ex_ismret;
  logic            ex_iscsr;
  logic [XLEN-1:0] ex_R_rs1;
  logic            flush;
  // Data bus
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_wen;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_wmask;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rdata;
  // WB side
  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_pc;
  logic [ILEN-1:0] wb_inst;
  logic [XLEN-1:0] ALUres;
  logic [XLEN-1:0] MemOut;
  logic [XLEN-1:0] R_rs1;
  logic [1:0]      RegSrc;
  logic            RegWr;
  logic            isecall;
  logic            ismret;
  logic            iscsr;
  // Forwarding
  logic                                mem_isRegWrite;
  logic [mem_stage_pkg::REG_ADDR_W-1:0] mem_raw_rd;
  logic [XLEN-1:0]                     mem_raw_Wdata;
  logic                                mem_raw_data_valid;

  modport master (
    input  ex_valid, ex_pc, ex_inst, ex_ALUres, ex_Rs2, ex_MemRd, ex_MemWr,
           ex_RegSrc, ex_RegWr, ex_isecall, ex_ismret, ex_iscsr, ex_R_rs1, flush,
           dmem_req_ready, dmem_rsp_valid, dmem_rdata, wb_ready,
    output ex_ready, dmem_req_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
           wb_valid, wb_pc, wb_inst, ALUres, MemOut, R_rs1, RegSrc, RegWr,
           isecall, ismret, iscsr, mem_isRegWrite, mem_raw_rd, mem_raw_Wdata,
           mem_raw_data_valid
  );

  modport slave (
    output ex_valid, ex_pc, ex_inst, ex_ALUres, ex_Rs2, ex_MemRd, ex_MemWr,
           ex_RegSrc, ex_RegWr, ex_isecall, ex_ismret, ex_iscsr, ex_R_rs1, flush,
           dmem_req_ready, dmem_rsp_valid, dmem_rdata, wb_ready,
    input  ex_ready, dmem_req_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
           wb_valid, wb_pc, wb_inst, ALUres, MemOut, R_rs1, RegSrc, RegWr,
           isecall, ismret, iscsr, mem_isRegWrite, mem_raw_rd, mem_raw_Wdata,
           mem_raw_data_valid
  );

endinterface : mem_stage_if
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_align                                                       |
// | Purpose  : Combinational byte-lane alignment for the memory stage.         |
// | Ports    : funct3_i / off_i   - access size code and byte offset           |
// |            rs2_i -> wdata_o   - store data shifted into its byte lanes     |
// |            wmask_o            - byte enables for the store                 |
// |            rdata_i -> ldata_o - load data shifted down and extended        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lsu_align #(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      off_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [7:0]      wmask_o,
  output logic [XLEN-1:0] ldata_o
);
  import mem_stage_pkg::*;

  logic [XLEN-1:0] w_shifted;
  logic [7:0]      w_base_mask;

  assign wdata_o   = rs2_i << {off_i, 3'b000};
  assign w_shifted = rdata_i >> {off_i, 3'b000};

  // Mask bits shifted past byte 7 fall off; such accesses are unsupported.
  always_comb begin
    w_base_mask = 8'h01;
    case (funct3_i[1:0])
      2'b00:   w_base_mask = 8'h01;
      2'b01:   w_base_mask = 8'h03;
      2'b10:   w_base_mask = 8'h0F;
      default: w_base_mask = 8'hFF;
    endcase
    wmask_o = w_base_mask << off_i;
  end

  always_comb begin
    ldata_o = w_shifted;
    case (funct3_i)
      F3_B:    ldata_o = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_H:    ldata_o = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    ldata_o = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_BU:   ldata_o = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      F3_HU:   ldata_o = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      F3_WU:   ldata_o = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: ldata_o = w_shifted;
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_stage                                                       |
// | Purpose  : Memory-access pipeline stage. Holds one instruction, issues its |
// |            load/store on the data bus, aligns/extends load data and        |
// |            presents the registered result to WB with forwarding info.      |
// | Ports    : clk, rst - clock, asynchronous active-high reset                |
// |            bus      - mem_stage_if.master (EX, data bus, WB, forwarding)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_stage #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.master bus
);
  import mem_stage_pkg::*;

  mem_state_e state_q, state_d;
  logic       kill_q, kill_d;

  logic [XLEN-1:0] pc_q, alures_q, rs2_q, rs1_q, memout_q;
  logic [ILEN-1:0] inst_q;
  logic [1:0]      regsrc_q;
  logic            regwr_q, memwr_q, isecall_q, ismret_q, iscsr_q;

  logic            w_ex_ready, w_accept, w_is_mem, w_kill_now, w_capture, w_in_req;
  logic [XLEN-1:0] w_wdata, w_ldata;
  logic [7:0]      w_wmask;

  assign w_ex_ready = ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && bus.wb_ready)) && !kill_q;
  // A flush swallows any instruction offered in the same cycle.
  assign w_accept   = bus.ex_valid && w_ex_ready && !bus.flush;
  assign w_is_mem   = bus.ex_MemRd || bus.ex_MemWr;
  // Flush arriving together with the response must still discard it.
  assign w_kill_now = kill_q || bus.flush;
  assign w_in_req   = (state_q == ST_REQ);

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    w_capture = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (w_accept) state_d = w_is_mem ? ST_REQ : ST_FULL;
      end
      ST_REQ: begin
        kill_d = w_kill_now;
        if (bus.dmem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        kill_d = w_kill_now;
        if (bus.dmem_rsp_valid) begin
          if (w_kill_now) begin
            state_d = ST_EMPTY;
            kill_d  = 1'b0;
          end else begin
            state_d   = ST_FULL;
            w_capture = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (bus.flush)         state_d = ST_EMPTY;
        else if (bus.wb_ready) state_d = w_accept ? (w_is_mem ? ST_REQ : ST_FULL) : ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      kill_q    <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      alures_q  <= '0;
      rs2_q     <= '0;
      rs1_q     <= '0;
      memout_q  <= '0;
      regsrc_q  <= '0;
      regwr_q   <= 1'b0;
      memwr_q   <= 1'b0;
      isecall_q <= 1'b0;
      ismret_q  <= 1'b0;
      iscsr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (w_accept) begin
        pc_q      <= bus.ex_pc;
        inst_q    <= bus.ex_inst;
        alures_q  <= bus.ex_ALUres;
        rs2_q     <= bus.ex_Rs2;
        rs1_q     <= bus.ex_R_rs1;
        memout_q  <= '0;
        regsrc_q  <= bus.ex_RegSrc;
        regwr_q   <= bus.ex_RegWr;
        memwr_q   <= bus.ex_MemWr;
        isecall_q <= bus.ex_isecall;
        ismret_q  <= bus.ex_ismret;
        iscsr_q   <= bus.ex_iscsr;
      end else if (w_capture) begin
        memout_q <= memwr_q ? '0 : w_ldata;
      end
    end
  end

  lsu_align #(.XLEN(XLEN)) u_lsu_align (
    .funct3_i (inst_q[14:12]),
    .off_i    (alures_q[2:0]),
    .rs2_i    (rs2_q),
    .rdata_i  (bus.dmem_rdata),
    .wdata_o  (w_wdata),
    .wmask_o  (w_wmask),
    .ldata_o  (w_ldata)
  );

  assign bus.ex_ready = w_ex_ready;

  // Bus outputs are held at zero outside the request phase.
  assign bus.dmem_req_valid = w_in_req;
  assign bus.dmem_addr      = w_in_req ? {alures_q[XLEN-1:3], 3'b000} : '0;
  assign bus.dmem_wen       = w_in_req && memwr_q;
  assign bus.dmem_wdata     = w_in_req ? w_wdata : '0;
  assign bus.dmem_wmask     = w_in_req ? w_wmask : '0;

  assign bus.wb_valid = (state_q == ST_FULL);
  assign bus.wb_pc    = pc_q;
  assign bus.wb_inst  = inst_q;
  assign bus.ALUres   = alures_q;
  assign bus.MemOut   = memout_q;
  assign bus.R_rs1    = rs1_q;
  assign bus.RegSrc   = regsrc_q;
  assign bus.RegWr    = regwr_q;
  assign bus.isecall  = isecall_q;
  assign bus.ismret   = ismret_q;
  assign bus.iscsr    = iscsr_q;

  assign bus.mem_isRegWrite     = (state_q != ST_EMPTY) && regwr_q && !kill_q;
  assign bus.mem_raw_rd         = inst_q[11:7];
  assign bus.mem_raw_Wdata      = (regsrc_q == REGSRC_MEM) ? memout_q : alures_q;
  assign bus.mem_raw_data_valid = (state_q == ST_FULL) && regwr_q && (regsrc_q != REGSRC_CSR) && !kill_q;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_stage                                                    |
// | Purpose  : Self-checking bench for mem_stage: ALU pass-through, loads and  |
// |            stores against a byte-level reference model, bus stalls,       |
// |            flushes and asynchronous reset.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(64), .ILEN(32)) bus ();
  mem_stage #(.XLEN(64), .ILEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference: build the loaded value byte by byte, then extend.
  function automatic logic [63:0] model_load(input logic [2:0] f3, input int off, input logic [63:0] rdata);
    logic [63:0] v;
    int nb;
    nb = 1 << f3[1:0];
    v  = '0;
    for (int b = 0; b < nb; b++)
      if (off + b < 8) v[8*b +: 8] = rdata[8*(off+b) +: 8];
    if (!f3[2] && nb < 8 && v[8*nb-1])
      for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [2:0] f3, input int off);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < (1 << f3[1:0]); b++)
      if (off + b < 8) m[off+b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] rs2, input int off);
    logic [63:0] d;
    d = '0;
    for (int b = 0; b + off < 8; b++) d[8*(off+b) +: 8] = rs2[8*b +: 8];
    return d;
  endfunction

  task automatic drive_idle();
    bus.ex_valid = 0; bus.ex_pc = '0; bus.ex_inst = '0; bus.ex_ALUres = '0;
    bus.ex_Rs2 = '0; bus.ex_MemRd = 0; bus.ex_MemWr = 0; bus.ex_RegSrc = 2'd0;
    bus.ex_RegWr = 0; bus.ex_isecall = 0; bus.ex_ismret = 0; bus.ex_iscsr = 0;
    bus.ex_R_rs1 = '0; bus.flush = 0; bus.dmem_req_ready = 0;
    bus.dmem_rsp_valid = 0; bus.dmem_rdata = '0; bus.wb_ready = 0;
  endtask

  task automatic drive_alu(input logic [63:0] res, input logic [4:0] rd);
    bus.ex_valid = 1; bus.ex_pc = 64'h200 + res; bus.ex_inst = {20'h0, rd, 7'h33};
    bus.ex_ALUres = res; bus.ex_MemRd = 0; bus.ex_MemWr = 0; bus.ex_RegSrc = 2'd0;
    bus.ex_RegWr = 1; bus.ex_iscsr = 0; bus.ex_isecall = 0; bus.ex_ismret = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    compared++;
    if ({bus.dmem_req_valid, bus.dmem_addr, bus.dmem_wen, bus.dmem_wdata, bus.dmem_wmask,
         bus.wb_valid, bus.wb_pc, bus.wb_inst, bus.ALUres, bus.MemOut, bus.R_rs1, bus.RegSrc,
         bus.RegWr, bus.isecall, bus.ismret, bus.iscsr, bus.mem_isRegWrite, bus.mem_raw_rd,
         bus.mem_raw_Wdata, bus.mem_raw_data_valid} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: some output nonzero, wb_valid=%b req_valid=%b MemOut=%h", bus.wb_valid, bus.dmem_req_valid, bus.MemOut);
    end
    compared++;
    if (bus.ex_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ex_ready: got %b expected 1", bus.ex_ready); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    logic [63:0] vals [3];
    logic [63:0] rs1;
    @(negedge clk);
    drive_alu(64'h1234, 5'd5);
    bus.ex_pc = 64'h100;
    compared++;
    if (bus.ex_ready !== 1'b1) begin mismatched++; $display("FAIL alu_accept_ready: got %b expected 1", bus.ex_ready); end
    @(negedge clk);
    bus.ex_valid = 0;
    compared++;
    if ({bus.wb_valid, bus.ALUres, bus.mem_raw_data_valid, bus.mem_raw_rd, bus.mem_raw_Wdata, bus.mem_isRegWrite, bus.wb_pc}
        !== {1'b1, 64'h1234, 1'b1, 5'd5, 64'h1234, 1'b1, 64'h100}) begin
      mismatched++;
      $display("FAIL alu_result: got wb_valid=%b ALUres=%h dv=%b rd=%0d wdata=%h expected 1/1234/1/5/1234", bus.wb_valid, bus.ALUres, bus.mem_raw_data_valid, bus.mem_raw_rd, bus.mem_raw_Wdata);
    end
    bus.wb_ready = 1;
    @(negedge clk);
    bus.wb_ready = 0;
    compared++;
    if ({bus.wb_valid, bus.mem_isRegWrite} !== 2'b00) begin mismatched++; $display("FAIL alu_drain: got wb_valid=%b isRegWrite=%b expected 0/0", bus.wb_valid, bus.mem_isRegWrite); end

    // Three back-to-back ops with WB always ready.
    for (int i = 0; i < 3; i++) vals[i] = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 3) begin
        compared++;
        if ({bus.wb_valid, bus.ALUres} !== {1'b1, vals[i-1]}) begin
          mismatched++;
          $display("FAIL b2b_result_%0d: got valid=%b ALUres=%h expected 1/%h", i, bus.wb_valid, bus.ALUres, vals[i-1]);
        end
      end
      if (i < 3) begin
        compared++;
        if (bus.ex_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.ex_ready); end
        drive_alu(vals[i], 5'(i + 1));
      end else begin
        bus.ex_valid = 0;
      end
      if (i == 4) begin
        compared++;
        if (bus.wb_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_end: wb_valid got %b expected 0", bus.wb_valid); end
      end
      bus.wb_ready = 1;
    end
    bus.wb_ready = 0;

    // CSR op: writes rd but its data is not forwardable from this stage.
    rs1 = {$urandom, $urandom};
    @(negedge clk);
    drive_alu(64'h77, 5'd9);
    bus.ex_RegSrc = 2'd2; bus.ex_iscsr = 1; bus.ex_isecall = 1; bus.ex_ismret = 1; bus.ex_R_rs1 = rs1;
    @(negedge clk);
    drive_idle();
    compared++;
    if ({bus.wb_valid, bus.iscsr, bus.isecall, bus.ismret, bus.R_rs1, bus.RegSrc, bus.mem_isRegWrite, bus.mem_raw_data_valid}
        !== {4'b1111, rs1, 2'd2, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL csr_payload: got csr=%b rs1=%h src=%0d isRW=%b dv=%b expected 1/%h/2/1/0", bus.iscsr, bus.R_rs1, bus.RegSrc, bus.mem_isRegWrite, bus.mem_raw_data_valid, rs1);
    end
    bus.wb_ready = 1;
    @(negedge clk);
    bus.wb_ready = 0;
  endtask

  // One load/store through the bus with configurable stall lengths.
  task automatic mem_op(input string name, input logic [2:0] f3, input bit store, input logic [63:0] addr,
                        input logic [63:0] rs2, input logic [63:0] rdata, input int req_wait, input int rsp_wait,
                        input logic [63:0] exp_out, input logic [63:0] exp_wdata, input logic [7:0] exp_wmask);
    logic [63:0] pc;
    logic [31:0] inst;
    pc   = addr ^ 64'h4000;
    inst = {17'h0, f3, 5'd10, store ? 7'h23 : 7'h03};
    @(negedge clk);
    bus.ex_valid = 1; bus.ex_pc = pc; bus.ex_inst = inst; bus.ex_ALUres = addr; bus.ex_Rs2 = rs2;
    bus.ex_MemRd = !store; bus.ex_MemWr = store; bus.ex_RegSrc = store ? 2'd0 : 2'd1; bus.ex_RegWr = !store;
    compared++;
    if (bus.ex_ready !== 1'b1) begin mismatched++; $display("FAIL %s_accept: ex_ready got %b expected 1", name, bus.ex_ready); end
    @(negedge clk);
    bus.ex_valid = 0;
    for (int c = 0; c <= req_wait; c++) begin
      compared++;
      if ({bus.dmem_req_valid, bus.dmem_wen, bus.dmem_addr, bus.dmem_wdata, bus.dmem_wmask, bus.ex_ready, bus.wb_valid}
          !== {1'b1, store, addr & ~64'h7, exp_wdata, exp_wmask, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL %s_req_%0d: got v=%b wen=%b addr=%h wdata=%h wmask=%h rdy=%b wbv=%b expected 1/%b/%h/%h/%h/0/0", name, c,
                 bus.dmem_req_valid, bus.dmem_wen, bus.dmem_addr, bus.dmem_wdata, bus.dmem_wmask, bus.ex_ready, bus.wb_valid,
                 store, addr & ~64'h7, exp_wdata, exp_wmask);
      end
      if (c == req_wait) bus.dmem_req_ready = 1;
      @(negedge clk);
    end
    bus.dmem_req_ready = 0;
    for (int c = 0; c <= rsp_wait; c++) begin
      compared++;
      if ({bus.dmem_req_valid, bus.ex_ready, bus.wb_valid} !== 3'b000) begin
        mismatched++;
        $display("FAIL %s_wait_%0d: got req_valid=%b ex_ready=%b wb_valid=%b expected 0/0/0", name, c, bus.dmem_req_valid, bus.ex_ready, bus.wb_valid);
      end
      if (c == rsp_wait) begin bus.dmem_rsp_valid = 1; bus.dmem_rdata = rdata; end
      @(negedge clk);
    end
    bus.dmem_rsp_valid = 0; bus.dmem_rdata = {$urandom, $urandom};
    compared++;
    if ({bus.wb_valid, bus.MemOut, bus.mem_raw_Wdata, bus.wb_pc, bus.wb_inst, bus.ex_ready, bus.mem_isRegWrite, bus.mem_raw_data_valid}
        !== {1'b1, exp_out, store ? addr : exp_out, pc, inst, 1'b0, !store, !store}) begin
      mismatched++;
      $display("FAIL %s_result: got wbv=%b MemOut=%h fwd=%h isRW=%b dv=%b expected 1/%h/%h/%b/%b", name, bus.wb_valid, bus.MemOut,
               bus.mem_raw_Wdata, bus.mem_isRegWrite, bus.mem_raw_data_valid, exp_out, store ? addr : exp_out, !store, !store);
    end
    bus.wb_ready = 1;
    @(negedge clk);
    bus.wb_ready = 0;
    compared++;
    if ({bus.wb_valid, bus.ex_ready} !== 2'b01) begin mismatched++; $display("FAIL %s_drain: got wbv=%b ex_ready=%b expected 0/1", name, bus.wb_valid, bus.ex_ready); end
  endtask

  task automatic test_load_store();
    mem_op("lb",  3'b000, 0, 64'h80000002, 64'h0, 64'h00000000_80FF0000, 0, 0, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 8'h04);
    mem_op("lbu", 3'b100, 0, 64'h80000002, 64'h0, 64'h00000000_80FF0000, 0, 0, 64'h00000000_000000FF, 64'h0, 8'h04);
    mem_op("lh",  3'b001, 0, 64'h80000002, 64'h0, 64'h00000000_80FF0000, 0, 0, 64'hFFFFFFFF_FFFF80FF, 64'h0, 8'h0C);
    mem_op("lb3", 3'b000, 0, 64'h80000003, 64'h0, 64'h00000000_80FF0000, 0, 0, 64'hFFFFFFFF_FFFFFF80, 64'h0, 8'h08);
    mem_op("sh",  3'b001, 1, 64'h80000006, 64'hABCD, 64'hDEAD_BEEF_0000_1111, 0, 0, 64'h0, 64'hABCD0000_00000000, 8'hC0);
    mem_op("stall", 3'b011, 0, 64'h80000010, 64'h0, 64'h01234567_89ABCDEF, 3, 2, 64'h01234567_89ABCDEF, 64'h0, 8'hFF);
  endtask

  task automatic test_random_mem();
    logic [2:0]  f3;
    logic [63:0] addr, rs2, rdata;
    bit          store;
    int          nb, off;
    for (int n = 0; n < 16; n++) begin
      store = bit'($urandom_range(0, 1));
      f3    = store ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      nb    = 1 << f3[1:0];
      off   = int'($urandom_range(0, 8 / nb - 1)) * nb;
      addr  = ({$urandom, $urandom} & ~64'h7) | 64'(off);
      rs2   = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      mem_op("rand", f3, store, addr, rs2, rdata, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             store ? 64'h0 : model_load(f3, off, rdata), model_wdata(rs2, off), model_wmask(f3, off));
    end
  endtask

  task automatic test_flush();
    // Flush while a load waits for its response.
    @(negedge clk);
    bus.ex_valid = 1; bus.ex_inst = {17'h0, 3'b011, 5'd4, 7'h03}; bus.ex_ALUres = 64'h80000040;
    bus.ex_MemRd = 1; bus.ex_RegSrc = 2'd1; bus.ex_RegWr = 1;
    @(negedge clk);
    drive_idle();
    bus.dmem_req_ready = 1;
    @(negedge clk);
    bus.dmem_req_ready = 0; bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    compared++;
    if ({bus.ex_ready, bus.wb_valid, bus.mem_isRegWrite} !== 3'b000) begin
      mismatched++;
      $display("FAIL flush_wait_killed: got ex_ready=%b wbv=%b isRW=%b expected 0/0/0", bus.ex_ready, bus.wb_valid, bus.mem_isRegWrite);
    end
    bus.dmem_rsp_valid = 1; bus.dmem_rdata = 64'h1111;
    @(negedge clk);
    bus.dmem_rsp_valid = 0;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if ({bus.wb_valid, bus.ex_ready, bus.mem_isRegWrite} !== 3'b010) begin
        mismatched++;
        $display("FAIL flush_wait_after_%0d: got wbv=%b ex_ready=%b isRW=%b expected 0/1/0", i, bus.wb_valid, bus.ex_ready, bus.mem_isRegWrite);
      end
      @(negedge clk);
    end
    // Flush in FULL, with a same-cycle offer that must be dropped.
    drive_alu(64'h99, 5'd3);
    @(negedge clk);
    drive_alu(64'h55, 5'd6);
    compared++;
    if (bus.wb_valid !== 1'b1) begin mismatched++; $display("FAIL flush_full_pre: wb_valid got %b expected 1", bus.wb_valid); end
    bus.flush = 1; bus.wb_ready = 1;
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      compared++;
      if ({bus.wb_valid, bus.mem_isRegWrite, bus.ex_ready} !== 3'b001) begin
        mismatched++;
        $display("FAIL flush_full_post_%0d: got wbv=%b isRW=%b ex_ready=%b expected 0/0/1", i, bus.wb_valid, bus.mem_isRegWrite, bus.ex_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.ex_valid = 1; bus.ex_inst = {17'h0, 3'b010, 5'd7, 7'h03}; bus.ex_ALUres = 64'h80000104;
    bus.ex_MemRd = 1; bus.ex_RegSrc = 2'd1; bus.ex_RegWr = 1;
    @(negedge clk);
    drive_idle();
    compared++;
    if ({bus.dmem_req_valid, bus.dmem_addr} !== {1'b1, 64'h80000100}) begin
      mismatched++;
      $display("FAIL areset_pre: got req_valid=%b addr=%h expected 1/80000100", bus.dmem_req_valid, bus.dmem_addr);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({bus.dmem_req_valid, bus.dmem_addr, bus.dmem_wmask, bus.wb_valid, bus.mem_isRegWrite, bus.ALUres, bus.mem_raw_rd, bus.ex_ready}
        !== {1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL areset_async: got req_valid=%b addr=%h wbv=%b isRW=%b ALUres=%h ex_ready=%b expected 0/0/0/0/0/1",
               bus.dmem_req_valid, bus.dmem_addr, bus.wb_valid, bus.mem_isRegWrite, bus.ALUres, bus.ex_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.dmem_req_valid, bus.wb_valid, bus.ex_ready} !== 3'b001) begin
      mismatched++;
      $display("FAIL areset_after: got req_valid=%b wbv=%b ex_ready=%b expected 0/0/1", bus.dmem_req_valid, bus.wb_valid, bus.ex_ready);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_random_mem();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mem_stage
`default_nettype wire
